// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_pkg
// Description : Shared definitions for the stochastic-computing decoders:
//               default binary width, decoder FSM state encoding and the
//               unipolar-count to bipolar-value conversion helper.
// Revision    : 1.0  initial release
// ============================================================================
package sc_pkg;

  // Default binary width. One maximal LFSR period is 2^DATAWD-1 samples.
  localparam int DATAWD = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_t;

  // Bipolar value of a window: 2*ones - winlen.
  // Evaluated in 32-bit signed arithmetic so that decoders with any DATAWD
  // can share it. The caller narrows the result to its own DATAWD+1 bits,
  // which always holds because |2*ones - winlen| <= winlen <= 2^DATAWD-1.
  function automatic int bi_from_cnt(input int cnt, input int winlen);
    return (2 * cnt) - winlen;
  endfunction

endpackage : sc_pkg
`default_nettype wire

// File: rtl/sc_win_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sc_win_cnt
// Description : Window sample counter. Counts enabled samples and flags the
//               WINLEN-th one; wraps to zero on that sample.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous reset, active-high
//               i_clear  - synchronous clear (priority over i_en)
//               i_en     - sample accepted this cycle
//               o_last   - this accepted sample is the WINLEN-th (comb.)
// Revision    : 1.0  initial release
// ============================================================================
module sc_win_cnt #(
  parameter int WIDTH  = 8,
  parameter int WINLEN = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_last
);

  // Counter holds the number of samples already accepted, so the WINLEN-th
  // sample arrives while it reads WINLEN-1.
  localparam logic [WIDTH-1:0] c_LAST = WIDTH'(WINLEN - 1);

  logic [WIDTH-1:0] r_cnt;

  assign o_last = i_en && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_last) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule : sc_win_cnt
`default_nettype wire

// File: rtl/sc_bi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sc_bi_decoder
// Description : Stochastic-to-binary converter for bipolar bitstreams.
//               Counts ones over a window of WINLEN accepted samples and
//               reports the ones count and the signed value 2*ones-WINLEN.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous reset, active-high
//               iStart  - one-cycle request to begin (or restart) a window
//               iEn     - sample qualifier for iBit
//               iBit    - stochastic bitstream input
//               oBusy   - window accumulation in progress
//               oValid  - one-cycle pulse on window completion
//               oCnt    - ones count of last completed window
//               oBi     - signed 2*oCnt-WINLEN of last completed window
// Revision    : 1.0  initial release
// ============================================================================
module sc_bi_decoder
  import sc_pkg::*;
#(
  parameter int DATAWD = sc_pkg::DATAWD,
  parameter int WINLEN = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iStart,
  input  logic                     iEn,
  input  logic                     iBit,
  output logic                     oBusy,
  output logic                     oValid,
  output logic        [DATAWD-1:0] oCnt,
  output logic signed [DATAWD:0]   oBi
);

  sc_state_t r_state;
  sc_state_t w_state_next;

  logic [DATAWD-1:0]     r_ones;
  logic [DATAWD-1:0]     r_cnt_out;
  logic signed [DATAWD:0] r_bi;

  logic                  w_clear;
  logic                  w_acc;
  logic                  w_load;
  logic                  w_last;
  logic [DATAWD-1:0]     w_ones_next;

  // A sample is accepted only while running and not being restarted; a
  // restart discards the current cycle's bit, including a final sample.
  assign w_acc       = (r_state == RUN) && !iStart && iEn;
  assign w_ones_next = r_ones + {{(DATAWD-1){1'b0}}, iBit};

  sc_win_cnt #(
    .WIDTH  (DATAWD),
    .WINLEN (WINLEN)
  ) u_win_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_acc),
    .o_last  (w_last)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_state_next = RUN;
          w_clear      = 1'b1;
        end
      end
      RUN: begin
        if (iStart) begin
          w_clear = 1'b1;
        end else if (w_acc && w_last) begin
          w_state_next = DONE;
          w_load       = 1'b1;
        end
      end
      DONE: begin
        if (iStart) begin
          w_state_next = RUN;
          w_clear      = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Ones counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones <= '0;
    end else if (w_clear) begin
      r_ones <= '0;
    end else if (w_acc) begin
      r_ones <= w_ones_next;
    end
  end

  // Results include the bit accepted in the completing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_out <= '0;
      r_bi      <= '0;
    end else if (w_load) begin
      r_cnt_out <= w_ones_next;
      r_bi      <= (DATAWD+1)'(bi_from_cnt(int'(w_ones_next), WINLEN));
    end
  end

  assign oBusy  = (r_state == RUN);
  assign oValid = (r_state == DONE);
  assign oCnt   = r_cnt_out;
  assign oBi    = r_bi;

endmodule : sc_bi_decoder
`default_nettype wire

// File: tb/tb_sc_bi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_bi_decoder
// Description : Directed self-checking bench for sc_bi_decoder (DATAWD=8,
//               WINLEN=255).
// Revision    : 1.0  initial release
// ============================================================================
module tb_sc_bi_decoder;

  logic              clk;
  logic              rst;
  logic              iStart;
  logic              iEn;
  logic              iBit;
  logic              oBusy;
  logic              oValid;
  logic [7:0]        oCnt;
  logic signed [8:0] oBi;

  int ntot  = 0;
  int npass = 0;

  sc_bi_decoder #(
    .DATAWD (8),
    .WINLEN (255)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iStart (iStart),
    .iEn    (iEn),
    .iBit   (iBit),
    .oBusy  (oBusy),
    .oValid (oValid),
    .oCnt   (oCnt),
    .oBi    (oBi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst    = 1'b1;
    iStart = 1'b0;
    iEn    = 1'b0;
    iBit   = 1'b0;
    repeat (2) tick();
    check("rst_busy",  oBusy,  0);
    check("rst_valid", oValid, 0);
    check("rst_cnt",   oCnt,   0);
    check("rst_bi",    $signed(oBi), 0);
    rst = 1'b0;
    tick();

    // 1: all ones, result +255 after exactly 255 samples
    iStart = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 255; i++) begin
      check("t1_busy",  oBusy,  1);
      check("t1_valid", oValid, 0);
      tick();
    end
    check("t1_done_valid", oValid, 1);
    check("t1_done_busy",  oBusy,  0);
    check("t1_cnt",        oCnt,   255);
    check("t1_bi",         $signed(oBi), 255);
    tick();
    check("t1_idle_valid", oValid, 0);
    check("t1_idle_busy",  oBusy,  0);
    check("t1_idle_cnt",   oCnt,   255);

    // 2: all zeros; the one on the start cycle is not counted
    iStart = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0; iBit = 1'b0;
    for (int i = 0; i < 255; i++) begin
      check("t2_valid", oValid, 0);
      tick();
    end
    check("t2_valid_end", oValid, 1);
    check("t2_cnt",       oCnt,   0);
    check("t2_bi",        $signed(oBi), -255);
    tick();

    // 3: alternating 1,0,... -> 128 ones, then a back-to-back window of ones
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 255; i++) begin
      iBit = ((i % 2) == 0);
      check("t3_valid", oValid, 0);
      tick();
    end
    check("t3_valid_end", oValid, 1);
    check("t3_cnt",       oCnt,   128);
    check("t3_bi",        $signed(oBi), 1);
    iStart = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0;
    check("t3b_busy_nogap", oBusy, 1);
    for (int i = 0; i < 255; i++) begin
      check("t3b_valid", oValid, 0);
      tick();
    end
    check("t3b_valid_end", oValid, 1);
    check("t3b_cnt",       oCnt,   255);
    check("t3b_bi",        $signed(oBi), 255);
    tick();

    // 4: iEn toggling, X on unqualified bits -> 509 cycles to complete
    iStart = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 509; i++) begin
      iEn  = ((i % 2) == 0);
      iBit = iEn ? 1'b1 : 1'bx;
      check("t4_valid", oValid, 0);
      tick();
    end
    iEn = 1'b1; iBit = 1'b1;
    check("t4_valid_end", oValid, 1);
    check("t4_cnt",       oCnt,   255);
    check("t4_bi",        $signed(oBi), 255);
    tick();

    // 5: restart mid-window after 99 ones, then zeros
    iStart = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 99; i++) begin
      check("t5_valid_pre", oValid, 0);
      tick();
    end
    iStart = 1'b1;
    tick();
    iStart = 1'b0; iBit = 1'b0;
    for (int i = 0; i < 255; i++) begin
      check("t5_valid", oValid, 0);
      check("t5_cnt_held", oCnt, 255);
      tick();
    end
    check("t5_valid_end", oValid, 1);
    check("t5_cnt",       oCnt,   0);
    check("t5_bi",        $signed(oBi), -255);
    tick();

    // 5b: restart coincident with the final sample wins
    iStart = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 254; i++) begin
      check("t5b_valid_pre", oValid, 0);
      tick();
    end
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("t5b_no_valid", oValid, 0);
    check("t5b_busy",     oBusy,  1);
    check("t5b_cnt_held", oCnt,   0);
    for (int i = 0; i < 255; i++) begin
      check("t5b_valid", oValid, 0);
      tick();
    end
    check("t5b_valid_end", oValid, 1);
    check("t5b_cnt",       oCnt,   255);
    check("t5b_bi",        $signed(oBi), 255);
    tick();

    // 6: asynchronous reset mid-window
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (49) tick();
    check("t6_busy_pre", oBusy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy",  oBusy,  0);
    check("t6_rst_valid", oValid, 0);
    check("t6_rst_cnt",   oCnt,   0);
    check("t6_rst_bi",    $signed(oBi), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      check("t6_post_valid", oValid, 0);
      check("t6_post_busy",  oBusy,  0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule : tb_sc_bi_decoder
`default_nettype wire
